// File: rtl/usb_sample_player.sv
// Streaming sample source: buffers 32-bit USB words, unpacks byte0..byte3 as signed samples at a programmable rate.
// Optional statistics counters are built only when SAMPLE_PLAYER_STATS_EN is defined.
module usb_sample_player #(
    parameter int DEPTH_LOG2  = 9,
    parameter int FULL_MARGIN = 4,
    parameter int RATE_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             usb_rd_data,
    input  logic                    usb_rd_data_valid,
    output logic                    usb_rd_full,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [RATE_WIDTH-1:0]   rate_div,
    output logic signed [7:0]       sample_out,
    output logic                    sample_valid,
    output logic [DEPTH_LOG2:0]     level,
    output logic [15:0]             underrun_count,
    output logic [15:0]             overflow_count
);

    // state   | meaning
    // IDLE    | not playing, output forced to 0, rate counter held at 0
    // PLAY    | emitting one sample per tick
    // STARVED | ticks arrived with no data; output 0 until a word shows up
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_STARVED} state_t;

    localparam logic [DEPTH_LOG2:0]   FULL_LVL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   AFULL_LVL = FULL_LVL - (DEPTH_LOG2+1)'(FULL_MARGIN);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [RATE_WIDTH-1:0] CNT_ONE   = {{(RATE_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0] mem_q [2**DEPTH_LOG2];

    state_t                  state_q, state_d;
    logic [RATE_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]             word_q, word_d;
    logic [1:0]              idx_q, idx_d;
    logic                    have_q, have_d;
    logic signed [7:0]       sample_out_q, sample_out_d;
    logic                    sample_valid_q, sample_valid_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    full_q, full_d;

    logic        tick, wr_en, pop, fifo_empty;
    logic [31:0] head;

    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign tick       = (state_q != S_IDLE) && enable && (cnt_q == rate_div);
    // A same-cycle pop never makes room for the incoming word.
    assign wr_en      = usb_rd_data_valid && !flush && (level_q != FULL_LVL);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        idx_d          = idx_q;
        have_d         = have_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        pop            = 1'b0;

        case (state_q)
            S_IDLE:  if (enable) state_d = S_PLAY;
            default: if (!enable) state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE || !enable) begin
            cnt_d = '0;
        end else if (cnt_q == rate_div) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (flush) begin
            have_d   = 1'b0;
            idx_d    = 2'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (tick) begin
                if (have_q) begin
                    sample_out_d   = $signed(word_q[{idx_q, 3'b000} +: 8]);
                    sample_valid_d = 1'b1;
                    if (idx_q == 2'd3) begin
                        have_d = 1'b0;
                        idx_d  = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                    state_d = S_PLAY;
                end else if (!fifo_empty) begin
                    // Head word is visible combinationally, so byte0 plays the tick it is popped.
                    pop            = 1'b1;
                    word_d         = head;
                    have_d         = 1'b1;
                    idx_d          = 2'd1;
                    sample_out_d   = $signed(head[7:0]);
                    sample_valid_d = 1'b1;
                    state_d        = S_PLAY;
                end else begin
                    sample_out_d = '0;
                    state_d      = S_STARVED;
                end
            end
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_en && !pop) begin
                level_d = level_q + LVL_ONE;
            end else if (!wr_en && pop) begin
                level_d = level_q - LVL_ONE;
            end
        end

        if (state_d == S_IDLE) sample_out_d = '0;
        full_d = (level_d >= AFULL_LVL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            word_q         <= '0;
            idx_q          <= 2'd0;
            have_q         <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            full_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            word_q         <= word_d;
            idx_q          <= idx_d;
            have_q         <= have_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            full_q         <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= usb_rd_data;
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign level        = level_q;
    assign usb_rd_full  = full_q;

`ifdef SAMPLE_PLAYER_STATS_EN
    logic        starve_evt, drop_evt;
    logic [15:0] underrun_q, underrun_d, overflow_q, overflow_d;

    assign starve_evt = tick && !flush && !have_q && fifo_empty;
    assign drop_evt   = usb_rd_data_valid && !flush && (level_q == FULL_LVL);

    always_comb begin
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        if (flush) begin
            underrun_d = '0;
            overflow_d = '0;
        end else begin
            if (starve_evt && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
            if (drop_evt && overflow_q != 16'hFFFF)   overflow_d = overflow_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_q <= '0;
            overflow_q <= '0;
        end else begin
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign underrun_count = underrun_q;
    assign overflow_count = overflow_q;
`else
    assign underrun_count = 16'd0;
    assign overflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_usb_sample_player.sv
// Bench for usb_sample_player: directed scenarios plus random traffic, checked each cycle against a queue-based model.
module tb_usb_sample_player;
    localparam int DL2    = 4;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic              clk, reset_n;
    logic [31:0]       usb_rd_data;
    logic              usb_rd_data_valid, usb_rd_full, enable, flush;
    logic [15:0]       rate_div;
    logic signed [7:0] sample_out;
    logic              sample_valid;
    logic [DL2:0]      level;
    logic [15:0]       underrun_count, overflow_count;

    usb_sample_player #(.DEPTH_LOG2(DL2), .FULL_MARGIN(MARGIN), .RATE_WIDTH(16)) dut (
        .clk(clk), .reset(reset_n),
        .usb_rd_data(usb_rd_data), .usb_rd_data_valid(usb_rd_data_valid), .usb_rd_full(usb_rd_full),
        .enable(enable), .flush(flush), .rate_div(rate_div),
        .sample_out(sample_out), .sample_valid(sample_valid), .level(level),
        .underrun_count(underrun_count), .overflow_count(overflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: active flag, rate count, word queue, queue of bytes still owed from the word being played.
    logic [31:0] mq[$];
    logic [7:0]  pq[$];
    logic        m_active, m_valid;
    logic [15:0] m_cnt, m_und, m_ovf;
    logic [7:0]  m_out;
    logic [7:0]  seen[$];

    task automatic model_reset();
        mq.delete(); pq.delete();
        m_active = 0; m_valid = 0; m_cnt = 0; m_und = 0; m_ovf = 0; m_out = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic en, input logic fl,
                              input logic [15:0] rd);
        int          sz;
        logic        tk;
        logic [31:0] w;
        sz = mq.size();
        tk = m_active && en && (m_cnt == rd);
        m_valid = 0;
        if (fl) begin
            mq.delete(); pq.delete();
`ifdef SAMPLE_PLAYER_STATS_EN
            m_und = 0; m_ovf = 0;
`endif
        end else begin
            if (tk) begin
                if (pq.size() > 0) begin
                    m_out = pq.pop_front(); m_valid = 1;
                end else if (sz > 0) begin
                    w = mq.pop_front();
                    m_out = w[7:0]; m_valid = 1;
                    pq.push_back(w[15:8]); pq.push_back(w[23:16]); pq.push_back(w[31:24]);
                end else begin
                    m_out = 0;
                    if (m_und != 16'hFFFF) m_und++;
                end
            end
            if (v) begin
                if (sz < DEPTH) mq.push_back(d);
                else if (m_ovf != 16'hFFFF) m_ovf++;
            end
        end
        if (!m_active || !en || m_cnt == rd) m_cnt = 0;
        else m_cnt = m_cnt + 16'd1;
        if (!en) m_out = 0;
        m_active = en;
    endtask

    task automatic compare_all();
        chk("sample_out", {24'd0, sample_out}, {24'd0, m_out});
        chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
        chk("level", {27'd0, level}, mq.size());
        chk("usb_rd_full", {31'd0, usb_rd_full}, {31'd0, (DEPTH - mq.size()) <= MARGIN});
`ifdef SAMPLE_PLAYER_STATS_EN
        chk("underrun_count", {16'd0, underrun_count}, {16'd0, m_und});
        chk("overflow_count", {16'd0, overflow_count}, {16'd0, m_ovf});
`else
        chk("underrun_count", {16'd0, underrun_count}, 32'd0);
        chk("overflow_count", {16'd0, overflow_count}, 32'd0);
`endif
        if (sample_valid) seen.push_back(sample_out);
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic en, input logic fl,
                        input logic [15:0] rd);
        usb_rd_data_valid = v; usb_rd_data = d; enable = en; flush = fl; rate_div = rd;
        @(posedge clk);
        model_edge(v, d, en, fl, rd);
        #1;
        compare_all();
    endtask

    initial begin
        int          last, pulses;
        logic [15:0] rd;
        logic        en, v, fl;
        reset_n = 0; usb_rd_data = 0; usb_rd_data_valid = 0; enable = 0; flush = 0; rate_div = 0;
        model_reset();

        // Reset held with live traffic
        usb_rd_data_valid = 1; usb_rd_data = 32'hDEADBEEF; enable = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            compare_all();
        end
        reset_n = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Byte order, back-to-back at rate_div=0
        seen.delete();
        step(1, 32'h04030201, 0, 0, 0);
        step(1, 32'h08070605, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
        chk("order_count", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("order_byte", {24'd0, seen[i]}, i + 1);
`ifdef SAMPLE_PLAYER_STATS_EN
        chk("order_underrun", {16'd0, underrun_count}, 3);
`else
        chk("order_underrun", {16'd0, underrun_count}, 0);
`endif
        step(0, 0, 0, 1, 0);

        // Rate divider 3: pulses every 4 cycles
        step(1, 32'h80FF7F01, 0, 0, 3);
        last = -1; pulses = 0;
        for (int i = 0; i < 22; i++) begin
            step(0, 0, 1, 0, 3);
            if (sample_valid) begin
                if (last >= 0) chk("rate_gap", i - last, 4);
                last = i; pulses++;
            end
        end
        chk("rate_pulses", pulses, 4);
        chk("rate_out_zero", {24'd0, sample_out}, 0);

        // Fill past full while idle, then drain at full speed
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, $urandom, 0, 0, 0);
        chk("full_level", {27'd0, level}, 16);
        chk("full_flag", {31'd0, usb_rd_full}, 1);
`ifdef SAMPLE_PLAYER_STATS_EN
        chk("full_overflow", {16'd0, overflow_count}, 4);
`else
        chk("full_overflow", {16'd0, overflow_count}, 0);
`endif
        for (int i = 0; i < 70; i++) step(0, 0, 1, 0, 0);

        // Disable mid-word then resume; then flush mid-word
        step(0, 0, 0, 1, 0);
        step(1, 32'h44332211, 0, 0, 0);
        seen.delete();
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        chk("resume_count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("resume_byte", {24'd0, seen[i]}, 32'h11 * (i + 1));
        step(0, 0, 0, 0, 0);
        step(1, 32'h0C0B0A09, 0, 0, 0);
        step(1, 32'h100F0E0D, 0, 0, 0);
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        step(1, 32'h55555555, 1, 1, 0);
        chk("flush_level", {27'd0, level}, 0);
        step(0, 0, 1, 0, 0);
        chk("flush_then_starve", {31'd0, sample_valid}, 0);

        // Random traffic
        rd = 0;
        for (int i = 0; i < 1500; i++) begin
            v  = (i < 750) ? ($urandom % 3 != 0) : ($urandom % 5 == 0);
            en = ($urandom % 16 != 0);
            fl = ($urandom % 64 == 0);
            if (!en) rd = 16'($urandom % 4);
            else if (rd < 3 && $urandom % 32 == 0) rd = rd + 16'd1;
            step(v, $urandom, en, fl, rd);
        end

        // Async reset in the middle of playback
        step(0, 0, 0, 0, 0);
        step(1, 32'h11223344, 0, 0, 0);
        step(1, 32'h55667788, 0, 0, 0);
        step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("areset_out", {24'd0, sample_out}, 0);
        chk("areset_valid", {31'd0, sample_valid}, 0);
        chk("areset_level", {27'd0, level}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            compare_all();
        end
        #3 reset_n = 1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
